vga_pixel_shifter: RTL and testbench
====================================

// Module: vga_pixel_shifter
// PURPOSE
// - Downstream consumer of VGA_data_controller: issues word requests, buffers returned 32-bit words, serialises them MSB-first into a 1-bpp pixel stream.
// - Each pixel is held PIX_REPEAT clocks (320 px across 640 active clocks); one word covers 64 clocks, 10 words per line.
// - Owns VGA_request_address; prefetches during back porch so pixel 0 is ready at ACTIVE entry.
// PARAMETERS
// - BASE_ADDR   32'h0   word address of first word of frame
// - PIX_REPEAT  2       clocks each pixel bit is held (power of 2, >=1)
// - H_ACTIVE    640     active clocks per line; WORDS_PER_LINE = H_ACTIVE/(32*PIX_REPEAT) = 10
// PORTS
// - clk                  in   1   pixel clock, 25 MHz
// - rst                  in   1   asynchronous, active-high reset
// - VGA_state            in   2   0 SYNC, 1 BACKPORCH, 2 ACTIVE, 3 FRONTPORCH
// - frame_start          in   1   1-cycle pulse at start of vertical sync
// - data_to_VGA          in   32  word returned by data controller
// - data_valid           in   1   data_to_VGA valid this cycle
// - word_req             out  1   request word at VGA_request_address
// - VGA_request_address  out  32  word address (increments by 1 per word)
// - pixel_out            out  1   registered pixel, 0 outside ACTIVE
// - underrun             out  1   sticky: buffer empty when a word was needed
// BEHAVIOUR
// - Reset: VGA_request_address=BASE_ADDR, word_req=0, pixel_out=0, underrun=0, buffer empty, counters 0.
// - Buffer: shift reg SR (32b, valid flag) + holding reg HR (32b, valid flag).
// - Fetch FSM F_IDLE/F_REQ:
//   - F_IDLE->F_REQ when VGA_state in {1,2}, HR empty, fetched<WORDS_PER_LINE; word_req=1 in F_REQ.
//   - F_REQ + data_valid: word -> HR (or SR if SR empty and not ACTIVE), address+1, fetched+1, ->F_IDLE.
//   - data_valid in F_IDLE ignored.
// - Prefetch: in BACKPORCH SR then HR fill; 2 words outstanding max.
// - Shift: in ACTIVE, rep_cnt 0..PIX_REPEAT-1, bit_cnt 0..31.
//   - pixel_out <= SR[31] each ACTIVE cycle, so 1-cycle latency vs VGA_state; top level delays syncs by 1.
//   - SR shifts left when rep_cnt wraps.
//   - At bit_cnt=31 & rep wrap: SR<=HR, HR empty; same-cycle data_valid lands in HR.
// - Underrun: SR reload needed but HR empty -> underrun=1, pixel_out=0 for rest of line, shifting halts; fetch continues.
// - Line end (ACTIVE->3): counters, SR/HR flags cleared; address <= line_base+WORDS_PER_LINE (realigns after underrun); fetched=0.
// - frame_start: address=BASE_ADDR, line_base=BASE_ADDR, buffer flushed, F_IDLE, underrun=0.
//   - Beats a same-cycle data_valid (word discarded).
// - rst mid-line: immediate async clear; output 0 until next back-porch prefetch.
// - Address wraps modulo 2^32 silently.
// STRUCTURE
// - vga_pkg: vga_state_t enum (SYNC, BACKPORCH, ACTIVE, FRONTPORCH), WORD_BITS=32, H_ACTIVE_DEF=640.
// - Sub-module vga_word_buffer: SR/HR pair, load/shift/flush, valid flags, empty/full.
// - Top holds fetch FSM, rep/bit counters, address/line_base regs, underrun flag.
// TESTING
// - Reset while VGA_state=2 -> word_req=0, pixel_out=0, addr=0, underrun=0 within same cycle.
// - BACKPORCH 48 clks, memory model returns data_valid 1 clk after word_req -> words at addr 0,1 fetched; word_req low; addr=2.
// - ACTIVE 640 clks, all words 32'hAAAAAAAA, pixel_out sampled from ACTIVE+1 -> 1,1,0,0 repeating; 10 words; addr=10 at line end.
// - Memory stalls after word 2 -> pixel_out=0 from clk 129 of line, underrun=1; addr=10 at line end.
// - frame_start coincident with data_valid mid-line -> addr=BASE_ADDR next clk, word discarded, underrun=0.
// - Two lines, word k = k -> line 2 requests addr 10..19; first pixels of line 2 = bits of 32'h0000000A, MSB first.

Source files
------------

// File: rtl/vga_pkg.sv
// +----------------------------------------------------------------------+
// | vga_pkg: shared types and constants for the VGA pixel path.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

  typedef enum logic [1:0] {
    SYNC       = 2'd0,
    BACKPORCH  = 2'd1,
    ACTIVE     = 2'd2,
    FRONTPORCH = 2'd3
  } vga_state_t;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_REQ  = 1'b1
  } fetch_state_t;

  localparam int WORD_BITS    = 32;
  localparam int H_ACTIVE_DEF = 640;

endpackage

`default_nettype wire

// File: rtl/vga_word_buffer.sv
// +----------------------------------------------------------------------+
// | vga_word_buffer: shift register SR backed by holding register HR.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_word_buffer
  import vga_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 load_sr_i,
  input  logic                 load_hr_i,
  input  logic                 shift_i,
  input  logic                 reload_i,
  input  logic [WORD_BITS-1:0] word_i,
  output logic                 msb_o,
  output logic                 sr_valid_o,
  output logic                 hr_valid_o,
  output logic                 empty_o
);

  logic [WORD_BITS-1:0] sr_q, sr_d, hr_q, hr_d;
  logic                 srv_q, srv_d, hrv_q, hrv_d;

  // A load into HR is applied after the reload so a word arriving on the
  // reload cycle refills HR instead of being lost.
  always_comb begin
    sr_d  = sr_q;
    srv_d = srv_q;
    hr_d  = hr_q;
    hrv_d = hrv_q;
    if (flush_i) begin
      srv_d = 1'b0;
      hrv_d = 1'b0;
    end else begin
      if (reload_i) begin
        sr_d  = hr_q;
        srv_d = hrv_q;
        hrv_d = 1'b0;
      end else if (shift_i) begin
        sr_d = {sr_q[WORD_BITS-2:0], 1'b0};
      end
      if (load_sr_i) begin
        sr_d  = word_i;
        srv_d = 1'b1;
      end
      if (load_hr_i) begin
        hr_d  = word_i;
        hrv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      hr_q  <= '0;
      srv_q <= 1'b0;
      hrv_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      hr_q  <= hr_d;
      srv_q <= srv_d;
      hrv_q <= hrv_d;
    end
  end

  assign msb_o      = sr_q[WORD_BITS-1];
  assign sr_valid_o = srv_q;
  assign hr_valid_o = hrv_q;
  assign empty_o    = !srv_q && !hrv_q;

endmodule

`default_nettype wire

// File: rtl/vga_pixel_shifter.sv
// +----------------------------------------------------------------------+
// | vga_pixel_shifter: fetches frame words and serialises them MSB-first |
// | into a 1-bpp pixel stream. Rev 1.0                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_pixel_shifter
  import vga_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          PIX_REPEAT = 2,
  parameter int          H_ACTIVE   = H_ACTIVE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           VGA_state,
  input  logic                 frame_start,
  input  logic [WORD_BITS-1:0] data_to_VGA,
  input  logic                 data_valid,
  output logic                 word_req,
  output logic [31:0]          VGA_request_address,
  output logic                 pixel_out,
  output logic                 underrun
);

  localparam int WORDS_PER_LINE = H_ACTIVE / (WORD_BITS * PIX_REPEAT);
  localparam int FW             = $clog2(WORDS_PER_LINE + 1);
  localparam int RW             = (PIX_REPEAT > 1) ? $clog2(PIX_REPEAT) : 1;
  localparam logic [FW-1:0] WPL_C    = FW'(WORDS_PER_LINE);
  localparam logic [RW-1:0] REP_LAST = RW'(PIX_REPEAT - 1);
  localparam logic [31:0]   WPL_ADDR = 32'(WORDS_PER_LINE);

  fetch_state_t  fst_q, fst_d;
  logic [31:0]   addr_q, addr_d, base_q, base_d;
  logic [FW-1:0] fetched_q, fetched_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [4:0]    bit_q, bit_d;
  logic          underrun_q, underrun_d, pixel_q, pixel_d, act_q, act_d;

  vga_state_t st;
  logic in_active, line_end, shifting, rep_wrap, reload;
  logic flush, load_sr, load_hr;
  logic msb, sr_valid, hr_valid, buf_empty;

  assign st        = vga_state_t'(VGA_state);
  assign in_active = (st == ACTIVE);
  assign line_end  = act_q && !in_active;
  assign shifting  = in_active && sr_valid;
  assign rep_wrap  = shifting && (rep_q == REP_LAST);
  assign reload    = rep_wrap && (bit_q == 5'd31);

  vga_word_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .load_sr_i  (load_sr),
    .load_hr_i  (load_hr),
    .shift_i    (rep_wrap && !reload),
    .reload_i   (reload),
    .word_i     (data_to_VGA),
    .msb_o      (msb),
    .sr_valid_o (sr_valid),
    .hr_valid_o (hr_valid),
    .empty_o    (buf_empty)
  );

  always_comb begin
    fst_d      = fst_q;
    addr_d     = addr_q;
    base_d     = base_q;
    fetched_d  = fetched_q;
    rep_d      = rep_q;
    bit_d      = bit_q;
    underrun_d = underrun_q;
    act_d      = in_active;
    pixel_d    = shifting ? msb : 1'b0;
    flush      = 1'b0;
    load_sr    = 1'b0;
    load_hr    = 1'b0;
    if (frame_start) begin
      fst_d      = F_IDLE;
      addr_d     = BASE_ADDR;
      base_d     = BASE_ADDR;
      fetched_d  = '0;
      rep_d      = '0;
      bit_d      = '0;
      underrun_d = 1'b0;
      pixel_d    = 1'b0;
      flush      = 1'b1;
    end else if (line_end) begin
      // Realign from the line base so a stalled line cannot skew the next.
      fst_d     = F_IDLE;
      addr_d    = base_q + WPL_ADDR;
      base_d    = base_q + WPL_ADDR;
      fetched_d = '0;
      rep_d     = '0;
      bit_d     = '0;
      flush     = 1'b1;
    end else begin
      case (fst_q)
        F_IDLE: begin
          if ((st == BACKPORCH || in_active) && !hr_valid && fetched_q < WPL_C)
            fst_d = F_REQ;
        end
        F_REQ: begin
          if (data_valid) begin
            if (buf_empty && !in_active) load_sr = 1'b1;
            else                         load_hr = 1'b1;
            addr_d    = addr_q + 32'd1;
            fetched_d = fetched_q + FW'(1);
            fst_d     = F_IDLE;
          end
        end
        default: fst_d = F_IDLE;
      endcase
      if (shifting) begin
        rep_d = rep_wrap ? '0 : rep_q + RW'(1);
        if (rep_wrap) bit_d = bit_q + 5'd1;
      end
      // Once every word of the line has been fetched, an empty HR is expected.
      if (reload && !hr_valid && fetched_q != WPL_C)
        underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fst_q      <= F_IDLE;
      addr_q     <= BASE_ADDR;
      base_q     <= BASE_ADDR;
      fetched_q  <= '0;
      rep_q      <= '0;
      bit_q      <= '0;
      underrun_q <= 1'b0;
      pixel_q    <= 1'b0;
      act_q      <= 1'b0;
    end else begin
      fst_q      <= fst_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      fetched_q  <= fetched_d;
      rep_q      <= rep_d;
      bit_q      <= bit_d;
      underrun_q <= underrun_d;
      pixel_q    <= pixel_d;
      act_q      <= act_d;
    end
  end

  assign word_req            = (fst_q == F_REQ);
  assign VGA_request_address = addr_q;
  assign pixel_out           = pixel_q;
  assign underrun            = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_shifter.sv
// +----------------------------------------------------------------------+
// | tb_vga_pixel_shifter: line-level vectors with a pixel scoreboard.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_vga_pixel_shifter;

  logic        clk, rst, frame_start, data_valid;
  logic [1:0]  VGA_state;
  logic [31:0] data_to_VGA;
  logic        word_req, pixel_out, underrun;
  logic [31:0] VGA_request_address;

  vga_pixel_shifter dut (
    .clk                 (clk),
    .rst                 (rst),
    .VGA_state           (VGA_state),
    .frame_start         (frame_start),
    .data_to_VGA         (data_to_VGA),
    .data_valid          (data_valid),
    .word_req            (word_req),
    .VGA_request_address (VGA_request_address),
    .pixel_out           (pixel_out),
    .underrun            (underrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    bit          index_mode;
    logic [31:0] fill;
    int          stall_after;
    logic [31:0] exp_addr;
    bit          exp_underrun;
  } line_vec_t;

  line_vec_t   vecs[4];
  bit          exp_q[$];
  int          n_vec = 0, n_bad = 0;

  // memory responder state
  bit          cur_index;
  logic [31:0] cur_fill, raddr, exp_req;
  int          cur_stall, delivered;
  bit          pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; afterwards outputs are sampled and the memory model advances.
  task automatic step();
    @(posedge clk);
    #1;
    if (data_valid) begin
      data_valid = 1'b0;
    end else if (pend) begin
      data_valid  = 1'b1;
      data_to_VGA = cur_index ? raddr : cur_fill;
      pend        = 1'b0;
      delivered++;
    end else if (word_req && (cur_stall < 0 || delivered < cur_stall)) begin
      pend  = 1'b1;
      raddr = VGA_request_address;
      if (cur_index) begin
        chk("req_addr", raddr, exp_req);
        exp_req = exp_req + 32'd1;
      end
    end
  endtask

  task automatic setup_mem(input bit idx, input logic [31:0] fill, input int stall,
                           input logic [31:0] base);
    cur_index = idx;
    cur_fill  = fill;
    cur_stall = stall;
    delivered = 0;
    pend      = 1'b0;
    exp_req   = base;
  endtask

  task automatic back_porch(input logic [31:0] base);
    VGA_state = 2'd1;
    repeat (48) step();
    chk("bp_addr", VGA_request_address, base + 32'd2);
    chk("bp_word_req", 32'(word_req), 32'd0);
  endtask

  task automatic blank();
    VGA_state = 2'd3;
    repeat (15) step();
    VGA_state = 2'd0;
    repeat (16) step();
  endtask

  task automatic run_line(input line_vec_t v);
    setup_mem(v.index_mode, v.fill, v.stall_after, v.base);
    for (int w = 0; w < 10; w++) begin
      logic [31:0] val;
      bit          avail;
      val   = v.index_mode ? v.base + 32'(w) : v.fill;
      avail = (v.stall_after < 0) || (w < v.stall_after);
      for (int b = 31; b >= 0; b--)
        repeat (2) exp_q.push_back(avail & val[b]);
    end
    back_porch(v.base);
    VGA_state = 2'd2;
    for (int c = 0; c < 640; c++) begin
      bit e;
      step();
      e = exp_q.pop_front();
      chk("pixel", 32'(pixel_out), 32'(e));
    end
    VGA_state = 2'd3;
    step();
    chk("end_addr", VGA_request_address, v.exp_addr);
    chk("end_underrun", 32'(underrun), 32'(v.exp_underrun));
    chk("end_pixel", 32'(pixel_out), 32'd0);
    blank();
  endtask

  initial begin
    int k;
    vecs[0] = '{32'd0,  1'b1, 32'h0,        -1, 32'd10, 1'b0};
    vecs[1] = '{32'd10, 1'b1, 32'h0,        -1, 32'd20, 1'b0};
    vecs[2] = '{32'd20, 1'b0, 32'hAAAAAAAA, -1, 32'd30, 1'b0};
    vecs[3] = '{32'd30, 1'b0, 32'hF0F0F0F0,  2, 32'd40, 1'b1};

    rst = 1'b1; VGA_state = 2'd2; frame_start = 1'b0;
    data_valid = 1'b0; data_to_VGA = '0;
    setup_mem(1'b0, 32'h0, -1, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word_req", 32'(word_req), 32'd0);
    chk("rst_pixel", 32'(pixel_out), 32'd0);
    chk("rst_addr", VGA_request_address, 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;

    VGA_state = 2'd0;
    repeat (4) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (4) step();

    for (int i = 0; i < 4; i++) run_line(vecs[i]);

    // frame_start colliding with a returning word in the middle of a line
    setup_mem(1'b0, 32'hAAAAAAAA, -1, 32'd40);
    back_porch(32'd40);
    chk("fs_pre_underrun", 32'(underrun), 32'd1);
    VGA_state = 2'd2;
    k = 0;
    while (data_valid !== 1'b1 && k < 300) begin
      step();
      k++;
    end
    chk("fs_dv_seen", 32'(data_valid), 32'd1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fs_addr", VGA_request_address, 32'd0);
    chk("fs_underrun", 32'(underrun), 32'd0);
    chk("fs_word_req", 32'(word_req), 32'd0);
    chk("fs_pixel", 32'(pixel_out), 32'd0);
    repeat (40) begin
      step();
      chk("fs_flushed_pixel", 32'(pixel_out), 32'd0);
    end
    VGA_state = 2'd3;
    step();
    chk("fs_end_addr", VGA_request_address, 32'd10);
    blank();

    // asynchronous reset in the middle of an active line
    setup_mem(1'b0, 32'hFFFFFFFF, -1, 32'd10);
    back_porch(32'd10);
    VGA_state = 2'd2;
    repeat (100) step();
    chk("pre_rst_pixel", 32'(pixel_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_word_req", 32'(word_req), 32'd0);
    chk("mid_rst_pixel", 32'(pixel_out), 32'd0);
    chk("mid_rst_addr", VGA_request_address, 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    #1 rst = 1'b0;
    data_valid = 1'b0;
    pend       = 1'b0;
    repeat (30) begin
      step();
      chk("post_rst_pixel", 32'(pixel_out), 32'd0);
    end
    blank();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
